// File: rtl/testro_pio_in_capture_if.sv
// Avalon-MM slave bus for the TestRO input-capture PIO.
// The host drives the master side and the PIO sits on the slave side.
interface testro_pio_in_capture_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/testro_pio_in_capture.sv
// Input PIO: synchronizes and optionally debounces an external bus, records
// selected edges in a W1C capture register and raises a masked level interrupt.
module testro_pio_in_capture #(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  testro_pio_in_capture_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  logic [WIDTH-1:0] sync_p0, sync_p1;
  logic [WIDTH-1:0] filt, filt_prev;
  logic [WIDTH-1:0] ev_raw, ev;
  logic [WIDTH-1:0] irqmask, edgecap, w1c;
  logic [1:0]       arm;
  logic             wr_en;
  logic [31:0]      rd_mux;

  // Stage 0/1: two-flop synchronizer on the asynchronous input bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= in_port;
      sync_p1 <= sync_p0;
    end
  end

  // Stage 2: per-bit debounce filter
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filt = sync_p1;
    end else begin : g_debounce
      localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
      logic [15:0] cnt [WIDTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filt <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_p1[i] == filt[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == LAST) begin
              filt[i] <= sync_p1[i];
              cnt[i]  <= '0;
            end else begin
              cnt[i] <= cnt[i] + 16'd1;
            end
          end
        end
      end
    end

    if (WIDTH < 32) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Stage 3: edge detect, gated until the arm counter saturates after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_prev <= '0;
      arm       <= '0;
    end else begin
      filt_prev <= filt;
      if (arm != 2'd3) arm <= arm + 2'd1;
    end
  end

  always_comb begin
    ev_raw = '0;
    if (EDGE_TYPE == 0)      ev_raw = filt & ~filt_prev;
    else if (EDGE_TYPE == 1) ev_raw = ~filt & filt_prev;
    else                     ev_raw = filt ^ filt_prev;
  end

  assign ev    = (arm == 2'd3) ? ev_raw : '0;
  assign wr_en = bus.chipselect && !bus.write_n;
  assign w1c   = (wr_en && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0:    rd_mux[WIDTH-1:0] = filt;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // Register file; a new edge in the clearing cycle keeps its bit set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
    end else begin
      if (wr_en && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      edgecap      <= (edgecap & ~w1c) | ev;
      bus.readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_testro_pio_in_capture.sv
// Scoreboard bench: a rising-edge instance checked against a history-based
// model, plus a debounced any-edge instance driven with directed pulses.
`timescale 1ns/1ps
module tb_testro_pio_in_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in0, in1;
  logic       irq0, irq1;

  always #5 clk = ~clk;

  testro_pio_in_capture_if bus0();
  testro_pio_in_capture_if bus1();

  testro_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0));

  testro_pio_in_capture #(.WIDTH(8), .EDGE_TYPE(2), .DEBOUNCE_CYCLES(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Read-valid tracking: readdata is due one edge after a read access.
  logic rv0, rv1;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
    end else begin
      rv0 <= bus0.chipselect && bus0.write_n;
      rv1 <= bus1.chipselect && bus1.write_n;
    end
  end

  always @(negedge clk) begin : monitor
    sb_t e;
    if (rv0) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb0_empty: got read 0x%0h, want a queued entry", bus0.readdata);
      end else begin
        e = q0.pop_front();
        chk(e.name, bus0.readdata, e.exp);
      end
    end
    if (rv1) begin
      if (q1.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb1_empty: got read 0x%0h, want a queued entry", bus1.readdata);
      end else begin
        e = q1.pop_front();
        chk(e.name, bus1.readdata, e.exp);
      end
    end
  end

  // Reference model for dut0: hist[i] is in0 at the (i+1)-th edge after reset
  // release. The filtered value seen before edge n is hist[n-3]; an edge is
  // capture-eligible from edge 4 on and compares hist[n-3] with hist[n-4].
  logic [7:0] hist[$];
  int         nedge;
  logic [7:0] mask_m, cap_m;

  function automatic logic [7:0] h(input int i);
    if (i < 0 || i >= hist.size()) return 8'h00;
    return hist[i];
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, h(nedge - 2)};
      2'd2:    return {24'h0, mask_m};
      2'd3:    return {24'h0, cap_m};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    hist.delete();
    nedge  = 0;
    mask_m = 8'h00;
    cap_m  = 8'h00;
  endtask

  task automatic tick();
    logic [7:0] ev, w1c;
    @(posedge clk);
    ev  = (nedge + 1 >= 4) ? (h(nedge - 2) & ~h(nedge - 3)) : 8'h00;
    w1c = 8'h00;
    if (bus0.chipselect && !bus0.write_n) begin
      if (bus0.address == 2'd2) mask_m = bus0.writedata[7:0];
      if (bus0.address == 2'd3) w1c    = bus0.writedata[7:0];
    end
    cap_m = (cap_m & ~w1c) | ev;
    hist.push_back(in0);
    nedge++;
    #1;
    chk("irq0_model", {31'd0, irq0}, {31'd0, |(cap_m & mask_m)});
  endtask

  task automatic drive(input int sel, input logic cs, input logic wn,
                       input logic [1:0] a, input logic [31:0] wd);
    bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.address = 2'd0; bus0.writedata = 32'h0;
    bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.address = 2'd0; bus1.writedata = 32'h0;
    if (sel == 0) begin
      bus0.chipselect = cs; bus0.write_n = wn; bus0.address = a; bus0.writedata = wd;
    end else begin
      bus1.chipselect = cs; bus1.write_n = wn; bus1.address = a; bus1.writedata = wd;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b1, 2'd0, 32'h0);
    tick();
  endtask

  task automatic wr(input int sel, input logic [1:0] a, input logic [31:0] wd);
    drive(sel, 1'b1, 1'b0, a, wd);
    tick();
  endtask

  task automatic rd0(input logic [1:0] a, input string nm);
    sb_t e;
    e.name = nm; e.exp = model_rd(a);
    q0.push_back(e);
    drive(0, 1'b1, 1'b1, a, 32'h0);
    tick();
  endtask

  task automatic rd0x(input logic [1:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    e.name = nm; e.exp = exp;
    q0.push_back(e);
    drive(0, 1'b1, 1'b1, a, 32'h0);
    tick();
  endtask

  task automatic rd1(input logic [1:0] a, input logic [31:0] exp, input string nm);
    sb_t e;
    e.name = nm; e.exp = exp;
    q1.push_back(e);
    drive(1, 1'b1, 1'b1, a, 32'h0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    in0 = 8'hFF;
    in1 = 8'h00;
    drive(0, 1'b0, 1'b1, 2'd0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readdata0", bus0.readdata, 32'h0);
    chk("rst_irq0", {31'd0, irq0}, 32'h0);
    chk("rst_readdata1", bus1.readdata, 32'h0);
    chk("rst_irq1", {31'd0, irq1}, 32'h0);
    reset_n = 1'b1;

    // Reset readback with the input high through release
    repeat (3) idle();
    rd0x(2'd0, 32'hFF, "rb_data");
    rd0x(2'd1, 32'h00, "rb_resv");
    rd0x(2'd2, 32'h00, "rb_mask");
    rd0x(2'd3, 32'h00, "rb_cap");
    chk("rb_irq", {31'd0, irq0}, 32'h0);

    // Rising capture and W1C
    in0 = 8'h00;
    repeat (4) idle();
    wr(0, 2'd2, 32'h1);
    in0 = 8'h01;
    idle(); chk("rise_irq_e1", {31'd0, irq0}, 32'h0);
    idle(); chk("rise_irq_e2", {31'd0, irq0}, 32'h0);
    idle(); chk("rise_irq_e3", {31'd0, irq0}, 32'h1);
    rd0x(2'd3, 32'h01, "rise_cap");
    wr(0, 2'd3, 32'h1);
    chk("w1c_irq", {31'd0, irq0}, 32'h0);
    rd0x(2'd3, 32'h00, "w1c_cap");

    // Clear of bit 2 in the same cycle as its new rising edge
    in0 = 8'h05;
    idle();
    idle();
    wr(0, 2'd3, 32'h4);
    rd0x(2'd3, 32'h04, "setwins_cap");
    wr(0, 2'd3, 32'h4);
    rd0x(2'd3, 32'h00, "setwins_clr");

    // Masking
    in0 = 8'h00;
    repeat (3) idle();
    wr(0, 2'd3, 32'hFF);
    wr(0, 2'd2, 32'h2);
    in0 = 8'h0A;
    repeat (3) idle();
    chk("mask_irq_set", {31'd0, irq0}, 32'h1);
    wr(0, 2'd3, 32'h2);
    chk("mask_irq_clr", {31'd0, irq0}, 32'h0);
    rd0x(2'd3, 32'h08, "mask_cap");
    wr(0, 2'd2, 32'hFFFF_FF08);
    chk("mask_irq_remask", {31'd0, irq0}, 32'h1);
    rd0x(2'd2, 32'h08, "mask_upper_ignored");

    // Debounce: a 3-cycle glitch never reaches the filter
    for (int t = 0; t < 16; t++) begin
      in1 = (t < 3) ? 8'h01 : 8'h00;
      rd1(2'd0, 32'h0, "db_short_data");
    end
    rd1(2'd3, 32'h0, "db_short_cap");
    repeat (4) idle();

    // Debounce: a 6-cycle pulse shows up 4 cycles late for 6 cycles
    for (int t = 0; t < 16; t++) begin
      in1 = (t < 6) ? 8'h01 : 8'h00;
      rd1(2'd0, (t >= 6 && t <= 11) ? 32'h1 : 32'h0, "db_long_data");
    end
    rd1(2'd3, 32'h1, "db_long_cap");
    chk("db_irq_masked", {31'd0, irq1}, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) in0 = 8'($urandom());
      case ($urandom_range(0, 5))
        0, 1:    idle();
        2:       rd0(2'($urandom_range(0, 3)), "rand_rd");
        3:       wr(0, 2'd2, $urandom());
        4:       wr(0, 2'd3, $urandom());
        default: wr(0, 2'($urandom_range(0, 1)), $urandom());
      endcase
    end
    for (int a = 0; a < 4; a++) rd0(2'(a), "rand_final_rd");

    // Mid-operation asynchronous reset
    in0 = 8'h00;
    repeat (3) idle();
    wr(0, 2'd3, 32'hFF);
    wr(0, 2'd2, 32'hFF);
    in0 = 8'h0F;
    repeat (3) idle();
    rd0x(2'd3, 32'h0F, "midrst_pre_cap");
    idle();
    chk("midrst_pre_irq", {31'd0, irq0}, 32'h1);
    #2;
    reset_n = 1'b0;
    #0.5;
    chk("midrst_irq_drop", {31'd0, irq0}, 32'h0);
    chk("midrst_readdata", bus0.readdata, 32'h0);
    #0.5;
    reset_n = 1'b1;
    model_reset();
    rd0x(2'd0, 32'h0, "post_rst_data");
    rd0x(2'd1, 32'h0, "post_rst_resv");
    rd0x(2'd2, 32'h0, "post_rst_mask");
    rd0x(2'd3, 32'h0, "post_rst_cap");
    repeat (4) idle();
    rd0(2'd0, "post_rst_data_model");
    rd0(2'd3, "post_rst_cap_model");
    repeat (3) idle();

    chk("sb0_drained", q0.size(), 32'h0);
    chk("sb1_drained", q1.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/testro_pio_in_capture.md
Name: testro_pio_in_capture

Overview:
- Avalon-MM slave input PIO: the read-side counterpart of the output PIO.
- Samples an external WIDTH-bit input bus through a 2-flop synchronizer and an optional per-bit debouncer.
- Records selected edges in a write-1-to-clear capture register and raises a level interrupt to the Nios/host for unmasked captured bits.
- Sits on the same system interconnect as the output PIOs, in the TestRO readout test path.

Parameters:
- WIDTH, 8, input bus width; legal range 1..32.
- EDGE_TYPE, 0, edge capture mode: 0 = rising, 1 = falling, 2 = any.
- DEBOUNCE_CYCLES, 0, consecutive stable cycles required before the filtered value changes; 0 = bypass; max 65535.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- in_port, input, WIDTH, external asynchronous input bus.
- readdata, output, 32, registered read data.
- irq, output, 1, level interrupt, active high.

Behaviour:
- Interface decision: one clock, clk; reset_n is asynchronous, active-low. Every flop clears on reset_n=0 regardless of clk.
- Reset values:
  - readdata = 0, irq = 0.
  - Synchronizer, filtered value d, d_prev, irqmask and edgecapture all = 0.
  - Debounce counters = 0.
- Synchronizer: s1 <= in_port; s2 <= s1. Combinational logic never sees in_port directly.
- Debounce, per bit:
  - If DEBOUNCE_CYCLES == 0, d = s2.
  - Otherwise cnt clears whenever s2 == d.
  - When s2 != d, cnt increments each cycle. When cnt reaches DEBOUNCE_CYCLES-1 with s2 still != d, d <= s2 and cnt <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never reaches d.
- Edge detect: d_prev <= d every cycle.
  - ev = d & ~d_prev (rising), ~d & d_prev (falling), or d ^ d_prev (any).
- Arm: 2-bit arm counter counts 0..3 after reset release.
  - ev is ignored until the counter saturates at 3.
  - Prevents spurious capture from flops leaving reset.
- Register map, 32-bit:
  - addr 0, DATA, RO: {0, d}. Writes ignored.
  - addr 1, reserved: reads 0, writes ignored.
  - addr 2, IRQMASK, RW: bits [WIDTH-1:0]. Upper bits read 0.
  - addr 3, EDGECAPTURE, R/W1C: bits [WIDTH-1:0]. Upper bits read 0.
- Write accepted when chipselect && !write_n. Takes effect at that clk edge.
- EDGECAPTURE update: cap <= (cap & ~w1c) | ev, where w1c = writedata[WIDTH-1:0] on an addr-3 write.
  - Set wins: a new edge in the same cycle as its clear leaves the bit set.
- Read:
  - readdata <= mux(address), registered every clk edge.
  - Read latency is exactly 1 cycle; no wait states.
  - readdata reflects register contents before any same-cycle write.
- irq = |(cap & irqmask). Combinational from flops, so it updates the cycle after cap or mask changes.
- Latency, DEBOUNCE_CYCLES=0:
  - in_port stable before edge k: s2 valid after edge k+1.
  - cap bit set at edge k+2; irq high after edge k+2.
  - DATA readable at an access sampled at edge k+2, returned at edge k+3.
- With debounce: add DEBOUNCE_CYCLES cycles to d, cap and irq.
- Bits above WIDTH in writedata are ignored.
- Reset mid-operation: all capture, mask and filter state lost; the arm sequence restarts.

Test Plan:
- Reset/readback: hold reset_n=0 with in_port=8'hFF; release and read addr 0,1,2,3.
  - Required: 0xFF, 0, 0, 0; irq=0.
  - No capture despite the input being high at release.
- Rising capture (EDGE_TYPE=0):
  - Write IRQMASK=0x01; drive in_port 0x00->0x01.
  - Required: irq rises exactly 3 edges later; EDGECAPTURE reads 0x01.
  - Then write 0x01 to addr 3: irq falls the next cycle and EDGECAPTURE reads 0.
- Simultaneous set/clear:
  - Time a W1C of 0x04 to addr 3 in the same cycle bit 2 sees a new rising edge.
  - Required: EDGECAPTURE bit 2 remains 1.
- Masking:
  - Capture edges on bits 1 and 3 with IRQMASK=0x02, so irq=1.
  - Clear bit 1 only: irq=0 while EDGECAPTURE reads 0x08.
  - Write IRQMASK=0x08: irq=1 the next cycle.
- Debounce (DEBOUNCE_CYCLES=4, EDGE_TYPE=2):
  - 3-cycle pulse on bit 0: DATA stays 0x00 and there is no capture.
  - 6-cycle pulse: DATA shows 0x01 and EDGECAPTURE=0x01.
- Mid-op reset:
  - With EDGECAPTURE=0x0F and IRQMASK=0xFF, pulse reset_n low for 1 ns between edges.
  - Required: irq drops immediately, and all registers read 0 after release.
